inv_cipher_seq: RTL

- Iterative, clocked AES inverse cipher (decryption) controller.
- One shared round datapath, sequenced by an FSM and round counter: inv_shift_rows, then inv_sub_bytes, then add_round_key, then inv_mix_columns.
- Replaces the fully unrolled combinational inverse cipher where area matters; accepts one 128-bit ciphertext block at a time.
- Valid/ready handshakes on both input and output sides, so it can sit between a block source and sink.

---
 rtl/inv_cipher_seq.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/inv_cipher_seq.sv
// inv_cipher_seq: iterative AES inverse cipher (decryption) with valid/ready
// handshakes on both sides. One shared round datapath is reused for every
// round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_valid, o_ready  input handshake; i_data/i_key sampled on accept
//   i_data [127:0]    ciphertext block
//   i_key  [32*NK-1:0] cipher key (w[0] at the MSBs)
//   o_valid, i_ready  output handshake; o_data held stable until consumed
//   o_data [127:0]    plaintext block (registered)
//   o_busy            high while rounds are being computed (ROUND/FINAL)
module inv_cipher_seq #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [127:0]    i_data,
  input  logic [32*NK-1:0] i_key,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [127:0]    o_data,
  output logic            o_busy
);

  localparam int CW = $clog2(NR + 1);
  localparam int NW = 4 * (NR + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CW-1:0] CNT_FIRST = CW'(NR - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // GF(2^8) multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (aa & {8{b[i]}});
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n = row + 4*col sits at bits [127-8n -: 8]; row r is rotated right by r.
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c - r + 4) % 4);
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  logic [1:0]        fsm_q,   fsm_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [127:0]      state_q, state_d;
  logic [32*NK-1:0]  key_q,   key_d;
  logic [127:0]      data_q,  data_d;
  logic              valid_q, valid_d;

  logic [127:0] rk_s [0:NR];
  logic [127:0] round_in_s;
  logic [127:0] sub_s;
  logic [127:0] round_out_s;
  logic [127:0] final_s;
  logic         accept_s;

  // Key expansion from the latched key register; round key r is words 4r..4r+3.
  always_comb begin : key_expansion
    logic [31:0] w [NW];
    logic [31:0] temp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    temp = 32'h0;
    for (int i = 0; i < NK; i++) begin
      w[i] = key_q[32*NK-1-32*i -: 32];
    end
    for (int i = NK; i < NW; i++) begin
      if (i % NK == 0) begin
        temp = sub_word({w[i-1][23:0], w[i-1][31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if ((NK > 6) && (i % NK == 4)) begin
        temp = sub_word(w[i-1]);
      end else begin
        temp = w[i-1];
      end
      w[i] = w[i-NK] ^ temp;
    end
    for (int r = 0; r <= NR; r++) begin
      rk_s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  end

  // Shared round datapath. The key register is loaded on the accept edge, so
  // the initial AddRoundKey(rk[NR]) is folded into the first ROUND edge.
  always_comb begin : round_datapath
    if (cnt_q == CNT_FIRST) begin
      round_in_s = state_q ^ rk_s[NR];
    end else begin
      round_in_s = state_q;
    end
    sub_s       = inv_sr_sb(round_in_s);
    round_out_s = inv_mix(sub_s ^ rk_s[cnt_q]);
    final_s     = sub_s ^ rk_s[0];
  end

  // Input-side ready: free in IDLE, or in DONE when the sink frees the output.
  always_comb begin : ready_decode
    case (fsm_q)
      ST_IDLE: o_ready = 1'b1;
      ST_DONE: o_ready = i_ready;
      default: o_ready = 1'b0;
    endcase
  end

  assign accept_s = i_valid & o_ready;

  // FSM and datapath next-state.
  always_comb begin : next_state
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    key_d   = key_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (fsm_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = i_data;
          key_d   = i_key;
          cnt_d   = CNT_FIRST;
          fsm_d   = ST_ROUND;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_ROUND: begin
        state_d = round_out_s;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          fsm_d = ST_FINAL;
        end else begin
          fsm_d = ST_ROUND;
        end
      end
      ST_FINAL: begin
        data_d  = final_s;
        valid_d = 1'b1;
        fsm_d   = ST_DONE;
      end
      ST_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (i_valid) begin
            state_d = i_data;
            key_d   = i_key;
            cnt_d   = CNT_FIRST;
            fsm_d   = ST_ROUND;
          end else begin
            fsm_d = ST_IDLE;
          end
        end else begin
          fsm_d = ST_DONE;
        end
      end
      default: begin
        fsm_d   = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any block in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= '0;
      state_q <= 128'h0;
      key_q   <= '0;
      data_q  <= 128'h0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      key_q   <= key_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_busy  = (fsm_q == ST_ROUND) | (fsm_q == ST_FINAL);

endmodule
